// File: rtl/shift_delay_line.sv
// Clock-enabled shift-register delay line with per-stage valid bits,
// a run-time selectable output tap, flush, and occupancy reporting.
module shift_delay_line #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned DEPTH     = 15,
    parameter int unsigned RESET_VAL = 10,
    localparam int unsigned DW       = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in,
    input  logic [DW-1:0]    delay,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic [DW-1:0]    fill_count,
    output logic             full
);

    localparam logic [WIDTH-1:0] RST_D = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] d [DEPTH];
    logic [DEPTH-1:0] v;
    logic [DW-1:0]    tap;

    // Out-of-range selections clamp to the nearest legal tap.
    function automatic logic [DW-1:0] tap_index(input logic [DW-1:0] sel);
        if (sel == '0)
            return '0;
        else if (sel > DW'(DEPTH))
            return DW'(DEPTH - 1);
        else
            return sel - DW'(1);
    endfunction

    function automatic logic [DW-1:0] popcount(input logic [DEPTH-1:0] bits);
        logic [DW-1:0] c;
        c = '0;
        for (int k = 0; k < int'(DEPTH); k++)
            c = c + DW'(bits[k]);
        return c;
    endfunction

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                d[k] <= RST_D;
                v[k] <= 1'b0;
            end
        end else if (en) begin
            d[0] <= in;
            v[0] <= in_valid;
            for (int k = 1; k < int'(DEPTH); k++) begin
                d[k] <= d[k-1];
                v[k] <= v[k-1];
            end
        end
    end

    // Outputs depend only on registered state and the tap select.
    always_comb begin
        tap       = tap_index(delay);
        out       = d[0];
        out_valid = v[0];
        for (int k = 0; k < int'(DEPTH); k++) begin
            if (tap == DW'(k)) begin
                out       = d[k];
                out_valid = v[k];
            end
        end
    end

    assign fill_count = popcount(v);
    assign full       = (fill_count == DW'(DEPTH));

endmodule

// File: tb/tb_shift_delay_line.sv
// Scoreboard bench for shift_delay_line: a history-list model predicts every
// cycle's outputs, a separate monitor compares them on the falling edge.
module tb_shift_delay_line;

    localparam int W   = 4;
    localparam int D   = 15;
    localparam int RV  = 10;
    localparam int DWT = 4;

    logic           clk = 1'b0;
    logic           reset, en, flush, in_valid;
    logic [W-1:0]   in;
    logic [DWT-1:0] delay;
    logic [W-1:0]   out;
    logic           out_valid;
    logic [DWT-1:0] fill_count;
    logic           full;

    shift_delay_line #(.WIDTH(W), .DEPTH(D), .RESET_VAL(RV)) dut (
        .clk(clk), .reset(reset), .en(en), .flush(flush),
        .in_valid(in_valid), .in(in), .delay(delay),
        .out(out), .out_valid(out_valid),
        .fill_count(fill_count), .full(full)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         vld;
        logic [W-1:0] dat;
    } entry_t;

    typedef struct {
        int           cyc;
        logic [W-1:0] out;
        logic         ov;
        int           fc;
        logic         full;
    } exp_t;

    entry_t hist[$];   // newest accepted sample at index 0
    exp_t   exp_q[$];
    int     checks = 0;
    int     errors = 0;
    int     cycle  = 0;

    function automatic int eff_delay(input int dl);
        if (dl == 0) return 1;
        if (dl > D) return D;
        return dl;
    endfunction

    task automatic cyc(input logic r, input logic f, input logic e,
                       input logic iv, input int din, input int dl);
        exp_t x;
        int   ed;
        int   cnt;
        reset = r; flush = f; en = e; in_valid = iv;
        in = W'(din); delay = DWT'(dl);
        @(posedge clk);
        cycle++;
        if (r || f) begin
            hist.delete();
        end else if (e) begin
            hist.push_front('{vld: iv, dat: W'(din)});
            if (hist.size() > D) void'(hist.pop_back());
        end
        ed  = eff_delay(dl);
        cnt = 0;
        foreach (hist[i]) if (hist[i].vld) cnt++;
        x.cyc = cycle;
        if (hist.size() >= ed) begin
            x.out = hist[ed-1].dat;
            x.ov  = hist[ed-1].vld;
        end else begin
            x.out = W'(RV);
            x.ov  = 1'b0;
        end
        x.fc   = cnt;
        x.full = (cnt == D);
        exp_q.push_back(x);
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (out !== e.out) begin
                errors++;
                $display("FAIL out cyc=%0d got=%0d exp=%0d", e.cyc, out, e.out);
            end
            checks++;
            if (out_valid !== e.ov) begin
                errors++;
                $display("FAIL out_valid cyc=%0d got=%b exp=%b", e.cyc, out_valid, e.ov);
            end
            checks++;
            if (fill_count !== DWT'(e.fc)) begin
                errors++;
                $display("FAIL fill_count cyc=%0d got=%0d exp=%0d", e.cyc, fill_count, e.fc);
            end
            checks++;
            if (full !== e.full) begin
                errors++;
                $display("FAIL full cyc=%0d got=%b exp=%b", e.cyc, full, e.full);
            end
        end
    end

    initial begin
        reset = 1'b1; flush = 1'b0; en = 1'b0; in_valid = 1'b0;
        in = '0; delay = DWT'(5);

        // reset for two cycles with arbitrary inputs
        cyc(1, 0, 1, 1, 3, 5);
        cyc(1, 0, 1, 1, 9, 5);

        // default stream, delay 3, past the fill cap
        for (int i = 1; i <= 20; i++) cyc(0, 0, 1, 1, i, 3);

        // enable gaps with delay 2
        cyc(0, 1, 0, 0, 0, 2);
        cyc(0, 0, 1, 1, 5, 2);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 12, 2);
        cyc(0, 0, 1, 1, 6, 2);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0, 2);

        // delay 0 clamps to 1, delay 15 is the deepest tap
        for (int i = 1; i <= 5; i++) cyc(0, 0, 1, 1, i, 0);
        for (int i = 1; i <= 17; i++) cyc(0, 0, 1, 1, i, 15);

        // retap 4 -> 2 -> 4 mid-stream
        cyc(0, 1, 0, 0, 0, 4);
        for (int i = 1; i <= 20; i++)
            cyc(0, 0, 1, 1, i, (i >= 8 && i < 14) ? 2 : 4);

        // fill, drain one, flush with a concurrent input
        cyc(0, 1, 0, 0, 0, 1);
        for (int i = 0; i < 15; i++) cyc(0, 0, 1, 1, i, 1);
        cyc(0, 0, 1, 0, 4, 1);
        cyc(0, 1, 1, 1, 7, 1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 1, 1);

        // reset in the middle of a delay 4 stream
        for (int i = 1; i <= 5; i++) cyc(0, 0, 1, 1, i, 4);
        cyc(1, 0, 1, 1, 6, 4);
        for (int i = 7; i <= 14; i++) cyc(0, 0, 1, 1, i, 4);

        // randomized traffic
        for (int i = 0; i < 2000; i++)
            cyc(($urandom_range(99) == 0), ($urandom_range(99) < 3),
                ($urandom_range(99) < 70), ($urandom_range(99) < 75),
                int'($urandom_range(15)), int'($urandom_range(15)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_delay_line.md
# shift_delay_line

Parametrised, enable-gated shift-register delay line with per-stage valid tracking, a run-time selectable output tap, flush and occupancy reporting. Used in the datapath wherever a value must be retimed by a programmable number of clock-enabled cycles, e.g. aligning operands or results with a multi-cycle unit. It replaces ad-hoc hand-chained registers with one synthesisable block of configurable width and depth.

## Interface
Parameters:
- WIDTH, 4, data bits per stage
- DEPTH, 15, number of stages (≥ 1)
- RESET_VAL, 10, value loaded into every data stage on reset or flush
- DW, $clog2(DEPTH+1), width of the `delay` and `fill_count` ports (derived, not overridden)

Ports:
- clk  input  1  single clock, all state updates on posedge
- reset  input  1  synchronous, active-high; one clock, reset is synchronous and active-high
- en  input  1  shift enable
- flush  input  1  synchronous clear of pipeline contents (not of configuration)
- in_valid  input  1  qualifies `in`
- in  input  WIDTH  data entering stage 0
- delay  input  DW  selected delay in enabled cycles, legal 1..DEPTH
- out  output  WIDTH  data at the selected tap
- out_valid  output  1  valid bit at the selected tap
- fill_count  output  DW  number of stages holding valid data, 0..DEPTH
- full  output  1  all DEPTH stages valid

## Operation
- State: data stages `d[0..DEPTH-1]` and valid bits `v[0..DEPTH-1]`.
- Priority per posedge: reset > flush > en > hold.
- reset or flush: every `d[k]` ← RESET_VAL, every `v[k]` ← 0.
- en=1 (no reset/flush): `d[0]` ← in, `v[0]` ← in_valid; `d[k]` ← `d[k-1]`, `v[k]` ← `v[k-1]` for k ≥ 1; stage DEPTH-1 is discarded.
- en=0: all stages hold; inputs are ignored.
- Data shifts regardless of in_valid; an invalid entry carries in_valid=0 through the line.
- Tap select: effective delay `ed` = 1 if delay=0, DEPTH if delay>DEPTH, otherwise delay. out = `d[ed-1]`, out_valid = `v[ed-1]`.
- fill_count = popcount of `v`; full = (fill_count == DEPTH).
- All outputs are combinational functions of registered state plus `delay` only; there is no path from `in`, `in_valid`, or `en` to any output.

## Timing
- Reset values: out = RESET_VAL, out_valid = 0, fill_count = 0, full = 0. These values are visible in the cycle after the reset edge, for any `delay`.
- Latency: a sample accepted at enabled edge N appears on out/out_valid after the `ed`-th enabled edge counting N as the first. With en held at 1, this is `ed` clocks. Each cycle with en=0 adds one cycle.
- `delay` change: takes effect in the same cycle because it is a pure mux. No data is reordered. Samples at the output may repeat (delay increased) or be skipped (delay decreased), and this is the required behaviour.
- flush with en=1 in the same cycle: flush wins, and the input sample is dropped.
- Reset mid-stream: all in-flight samples are lost. The reset values above hold on the next cycle, and the line refills from stage 0.
- Full: does not block input. When en=1 and full=1, the oldest entry is shifted out, and fill_count changes by (in_valid − `v[DEPTH-1]`).
- fill_count never exceeds DEPTH and never wraps.

## Test plan
- Reset: assert reset for 2 cycles with arbitrary inputs, delay=5 -> out=10, out_valid=0, fill_count=0, full=0.
- Stream with defaults: delay=3, en=1, in_valid=1, in=1,2,3,… on consecutive cycles -> out=1 with out_valid=1 exactly 3 cycles after the first input edge, then 2,3,… each cycle; fill_count = 1,2,3,… (capped at 15).
- Enable gaps: delay=2; inputs 5, then en=0 for 3 cycles, then 6 -> 5 reaches out only after 2 enabled edges; out holds during en=0; no sample is duplicated or lost.
- Clamping and retap: delay=0 behaves as delay 1, and delay=15 behaves as 15 (with DEPTH=15 and DW=4, values above DEPTH are not representable). Streaming 1..20 with delay switched from 4 to 2 mid-stream -> out skips two samples with no glitch; switching back to 4 repeats two samples.
- Fill/full/flush: 15 consecutive valid inputs -> fill_count=15, full=1. A 16th input with in_valid=0 -> fill_count=14, full=0. Pulse flush together with en=1, in=7 -> next cycle fill_count=0, out=10, out_valid=0, and 7 never appears at out.
- Reset mid-stream: reset at cycle 6 of a delay=4 stream -> reset values are held the cycle after the reset edge; the first post-reset input appears 4 enabled cycles later.
